// File: rtl/regfile_mp_pkg.sv
// sigma_pkg: shared constants and types for the multi-port register file.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default register width and register count
//   rf_state_t                     : clear-controller state (CLEAR, RUN)
package sigma_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of the register file's read/write port signals.
//   read_addr    : NUM_RD x ADDR_W read addresses   (master -> slave)
//   read_data    : NUM_RD x DATA_W read data        (slave -> master)
//   write_addr   : NUM_WR x ADDR_W write addresses  (master -> slave)
//   write_data   : NUM_WR x DATA_W write data       (master -> slave)
//   write_enable : NUM_WR write strobes             (master -> slave)
//   ready        : clear sequence complete          (slave -> master)
interface regfile_mp_if
    import sigma_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
);

    logic [NUM_RD-1:0][ADDR_W-1:0] read_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] read_data;
    logic [NUM_WR-1:0][ADDR_W-1:0] write_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] write_data;
    logic [NUM_WR-1:0]             write_enable;
    logic                          ready;

    modport master (
        output read_addr, write_addr, write_data, write_enable,
        input  read_data, ready
    );

    modport slave (
        input  read_addr, write_addr, write_data, write_enable,
        output read_data, ready
    );

endinterface

// File: rtl/regfile_mp_clear_ctrl.sv
// regfile_clear_ctrl: post-reset clear sequencer for regfile_mp.
//   clk, reset_n : clock, synchronous active-low reset
//   clr_we       : high while in CLEAR; storage zeroes register clr_idx
//   clr_idx      : register currently being cleared (starts at 1)
//   ready        : high in RUN; forced low while reset_n is low
module regfile_clear_ctrl
    import sigma_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         state, state_next;
    logic [ADDR_W-1:0] idx_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_idx <= ADDR_W'(1);
        end else begin
            state   <= state_next;
            clr_idx <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = clr_idx;
        if (state == CLEAR) begin
            idx_next = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_IDX) begin
                state_next = RUN;
            end
        end
    end

    assign clr_we = (state == CLEAR);
    // Gated by reset_n so ready drops as soon as reset is applied, not one edge later.
    assign ready  = (state == RUN) && reset_n;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sequence.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : read_addr/read_data, write_addr/write_data/write_enable, ready
// Register 0 always reads 0; writes to it are discarded. On a same-address
// write collision the higher-index port wins.
// Optional macro REGFILE_BYPASS_EN: a read matching an enabled non-zero write
// address in the same cycle returns that write data (highest matching port);
// otherwise the read returns the pre-write value.
module regfile_mp
    import sigma_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    regfile_mp_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready;

    regfile_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .ready   (ready)
    );

    assign bus.ready = ready;

    // Ports are applied in ascending order so the last (highest) port's
    // assignment takes effect on a collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_idx] <= '0;
        end else if (ready) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (bus.write_enable[j] && (bus.write_addr[j] != '0)) begin
                    regs[bus.write_addr[j]] <= bus.write_data[j];
                end
            end
        end
    end

    always_comb begin
        bus.read_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (ready && (bus.read_addr[i] != '0)) begin
                bus.read_data[i] = regs[bus.read_addr[i]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (bus.write_enable[j] && (bus.write_addr[j] == bus.read_addr[i])) begin
                        bus.read_data[i] = bus.write_data[j];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    import sigma_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h5;
`else
    localparam logic [31:0] BYP_EXP = 32'h1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) bus ();

    regfile_mp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model: register contents plus "edges since reset release".
    logic [31:0] mem [DEPTH];
    bit          model_ready = 1'b0;
    int          rel_edges = 0;

    function automatic logic [31:0] exp_read(input logic [ADDR_W-1:0] a);
        logic [31:0] v;
        if (!(model_ready && reset_n) || a == 0) return 32'h0;
        v = mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++)
            if (bus.write_enable[j] && bus.write_addr[j] == a) v = bus.write_data[j];
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One clock: capture inputs, take the edge, update model, settle at edge+1.
    task automatic step();
        logic                      rst;
        logic [NUM_WR-1:0]         we;
        logic [NUM_WR-1:0][ADDR_W-1:0] wa;
        logic [NUM_WR-1:0][31:0]   wd;
        rst = reset_n;
        we  = bus.write_enable;
        wa  = bus.write_addr;
        wd  = bus.write_data;
        @(posedge clk);
        if (!rst) begin
            model_ready = 1'b0;
            rel_edges   = 0;
        end else if (!model_ready) begin
            rel_edges++;
            if (rel_edges == DEPTH - 1) begin
                model_ready = 1'b1;
                for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (we[j] && wa[j] != 0) mem[wa[j]] = wd[j];
        end
        #1;
    endtask

    task automatic idle_writes();
        bus.write_enable = '0;
        bus.write_addr   = '0;
        bus.write_data   = '0;
    endtask

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        reset_n = 1'b0;
        idle_writes();
        bus.read_addr = '0;

        // Reset held for 3 edges, with a write to 12 pending throughout clear.
        for (int e = 0; e < 3; e++) begin
            step();
            check("rst_ready", {31'b0, bus.ready}, 32'h0);
        end
        reset_n = 1'b1;
        bus.write_enable[0] = 1'b1;
        bus.write_addr[0]   = 5'd12;
        bus.write_data[0]   = 32'h1234;
        bus.read_addr[0]    = 5'd12;
        bus.read_addr[1]    = 5'd1;
        for (int e = 1; e <= 31; e++) begin
            check("clr_rdata0", bus.read_data[0], 32'h0);
            step();
            check($sformatf("clr_ready_e%0d", e), {31'b0, bus.ready}, (e == 31) ? 32'h1 : 32'h0);
        end
        idle_writes();
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.read_addr[0] = ADDR_W'(a);
            bus.read_addr[1] = ADDR_W'(DEPTH - 1 - a);
            #1;
            check($sformatf("zero_p0_a%0d", a), bus.read_data[0], 32'h0);
            check($sformatf("zero_p1_a%0d", a), bus.read_data[1], 32'h0);
        end

        // Directed table: write on one edge, read after it.
        vecs[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1, 5'd7, 32'h11,       1, 5'd7, 32'h22,   5'd7, 5'd0, 32'h22,       32'h0};
        vecs[2] = '{1, 5'd3, 32'hA,        1, 5'd4, 32'hB,    5'd3, 5'd4, 32'hA,        32'hB};
        vecs[3] = '{1, 5'd0, 32'hFFFF,     0, 5'd0, 32'h0,    5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{0, 5'd5, 32'h5555,     0, 5'd7, 32'h7777, 5'd5, 5'd7, 32'hDEADBEEF, 32'h22};
        vecs[5] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFF, 5'd0, 5'd12, 32'h0,       32'h0};
        for (int v = 0; v < 6; v++) begin
            bus.write_enable[0] = vecs[v].we0;
            bus.write_addr[0]   = vecs[v].wa0;
            bus.write_data[0]   = vecs[v].wd0;
            bus.write_enable[1] = vecs[v].we1;
            bus.write_addr[1]   = vecs[v].wa1;
            bus.write_data[1]   = vecs[v].wd1;
            step();
            idle_writes();
            bus.read_addr[0] = vecs[v].ra0;
            bus.read_addr[1] = vecs[v].ra1;
            #1;
            check($sformatf("vec%0d_rd0", v), bus.read_data[0], vecs[v].exp0);
            check($sformatf("vec%0d_rd1", v), bus.read_data[1], vecs[v].exp1);
        end

        // Same-cycle write/read of addr 9.
        bus.write_enable[0] = 1'b1;
        bus.write_addr[0]   = 5'd9;
        bus.write_data[0]   = 32'h1;
        step();
        bus.write_data[0]   = 32'h5;
        bus.read_addr[0]    = 5'd9;
        #1;
        check("bypass_same", bus.read_data[0], BYP_EXP);
        step();
        idle_writes();
        #1;
        check("bypass_after", bus.read_data[0], 32'h5);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                bus.write_enable[j] = ($urandom_range(0, 3) != 0);
                bus.write_addr[j]   = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7))
                                                                  : ADDR_W'($urandom_range(0, 31));
                bus.write_data[j]   = $urandom;
            end
            for (int i = 0; i < NUM_RD; i++)
                bus.read_addr[i] = ($urandom_range(0, 1) != 0) ? bus.write_addr[i % NUM_WR]
                                                               : ADDR_W'($urandom_range(0, 31));
            #1;
            check("rand_rd0", bus.read_data[0], exp_read(bus.read_addr[0]));
            check("rand_rd1", bus.read_data[1], exp_read(bus.read_addr[1]));
            check("rand_ready", {31'b0, bus.ready}, {31'b0, model_ready});
            step();
        end
        idle_writes();

        // Mid-operation reset with reg5 = 0x99.
        bus.write_enable[0] = 1'b1;
        bus.write_addr[0]   = 5'd5;
        bus.write_data[0]   = 32'h99;
        step();
        idle_writes();
        bus.read_addr[0] = 5'd5;
        #1;
        check("mid_pre_r5", bus.read_data[0], 32'h99);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, bus.ready}, 32'h0);
        check("mid_rst_rd", bus.read_data[0], 32'h0);
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            step();
            if (e == 30) check("mid_ready_e30", {31'b0, bus.ready}, 32'h0);
        end
        check("mid_ready_e31", {31'b0, bus.ready}, 32'h1);
        check("mid_r5_cleared", bus.read_data[0], 32'h0);
        check("mid_model_ready", {31'b0, bus.ready}, {31'b0, model_ready});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
